// File: rtl/pcmcia_host_master_if.sv
// Local request/response channel plus 8-bit PCMCIA/CF card bus, seen from the host initiator.
// master = host-side initiator view, slave = the card/requester side.
interface pcmcia_host_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_space;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rst_req;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_tmo;
    logic        rsp_nopack;
    logic [15:0] a;
    logic [7:0]  d_out;
    logic [7:0]  d_in;
    logic        d_oe;
    logic        ce1_n;
    logic        ce2_n;
    logic        reg_n;
    logic        oe_n;
    logic        we_n;
    logic        iord_n;
    logic        iowr_n;
    logic        wait_n;
    logic        inpack_n;
    logic        card_reset;

    modport master (
        input  req_valid, req_write, req_space, req_addr, req_wdata, rst_req,
        input  d_in, wait_n, inpack_n,
        output req_ready, rsp_valid, rsp_rdata, rsp_tmo, rsp_nopack,
        output a, d_out, d_oe, ce1_n, ce2_n, reg_n, oe_n, we_n, iord_n, iowr_n,
        output card_reset
    );

    modport slave (
        output req_valid, req_write, req_space, req_addr, req_wdata, rst_req,
        output d_in, wait_n, inpack_n,
        input  req_ready, rsp_valid, rsp_rdata, rsp_tmo, rsp_nopack,
        input  a, d_out, d_oe, ce1_n, ce2_n, reg_n, oe_n, we_n, iord_n, iowr_n,
        input  card_reset
    );
endinterface

// File: rtl/pcmcia_host_master.sv
// Host-side PCMCIA/CF initiator: turns single-byte requests into timed CE/REG/OE/WE/IORD/IOWR
// cycles, honours WAIT, samples INPACK on I/O reads and generates the card RESET pulse.
//
// state    | meaning
// IDLE     | ready for a request or a card reset command
// SETUP    | address/CE/REG (and write data) valid, strobes high
// STROBE   | selected strobe low for the minimum strobe time
// WAITX    | strobe extended while the card holds WAIT, bounded by WAIT_TMO
// HOLD     | strobe high, address/CE/REG/data still held
// RESP     | one-cycle response pulse
// CRST     | CARD_RESET asserted, bus idle
module pcmcia_host_master #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 1,
    parameter int WAIT_TMO   = 1024,
    parameter int RESET_CYC  = 64
) (
    input  logic clk,
    input  logic rst_n,
    pcmcia_host_master_if.master bus
);
    localparam int MAX_0 = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_1 = (MAX_0 > HOLD_CYC) ? MAX_0 : HOLD_CYC;
    localparam int MAX_2 = (MAX_1 > WAIT_TMO) ? MAX_1 : WAIT_TMO;
    localparam int MAX_3 = (MAX_2 > RESET_CYC) ? MAX_2 : RESET_CYC;
    localparam int CW    = $clog2(MAX_3 + 1);

    localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST    = CW'(WAIT_TMO - 1);
    localparam logic [CW-1:0] RESET_LAST  = CW'(RESET_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_WAITX, S_HOLD, S_RESP, S_CRST
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [1:0]    wait_sync, pack_sync;
    logic          wait_s, pack_s;
    logic [15:0]   addr_q;
    logic [7:0]    wdata_q, rdata_q;
    logic          write_q, io_q, attr_q, tmo_q, pack_q;
    logic          accept, capture, tmo_set, bus_on, strobe_on;

    assign wait_s = wait_sync[1];
    assign pack_s = pack_sync[1];
    assign accept = (state_q == S_IDLE) && !bus.rst_req && bus.req_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_sync <= 2'b11;
            pack_sync <= 2'b11;
        end else begin
            wait_sync <= {wait_sync[0], bus.wait_n};
            pack_sync <= {pack_sync[0], bus.inpack_n};
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        tmo_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.rst_req)        state_d = S_CRST;
                else if (bus.req_valid) state_d = S_SETUP;
            end
            S_SETUP:  if (cnt_q == SETUP_LAST) state_d = S_STROBE;
            S_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    if (!wait_s) begin
                        state_d = S_WAITX;
                    end else begin
                        state_d = S_HOLD;
                        capture = 1'b1;
                    end
                end
            end
            S_WAITX: begin
                if (wait_s) begin
                    state_d = S_HOLD;
                    capture = 1'b1;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_HOLD;
                    capture = 1'b1;
                    tmo_set = 1'b1;
                end
            end
            S_HOLD:  if (cnt_q == HOLD_LAST) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            S_CRST:  if (cnt_q == RESET_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One shared phase counter, restarted on every state change and saturating rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)  cnt_q <= '0;
            else if (cnt_q != '1)    cnt_q <= cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            io_q    <= 1'b0;
            attr_q  <= 1'b0;
            tmo_q   <= 1'b0;
            pack_q  <= 1'b0;
        end else if (accept) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            write_q <= bus.req_write;
            io_q    <= (bus.req_space == 2'd2);
            attr_q  <= (bus.req_space == 2'd1);
            rdata_q <= '0;
            tmo_q   <= 1'b0;
            pack_q  <= 1'b0;
        end else begin
            if (capture && !write_q)                   rdata_q <= bus.d_in;
            if (tmo_set)                               tmo_q   <= 1'b1;
            if (strobe_on && io_q && !write_q && !pack_s) pack_q <= 1'b1;
        end
    end

    assign bus_on    = (state_q == S_SETUP) || (state_q == S_STROBE) ||
                       (state_q == S_WAITX) || (state_q == S_HOLD);
    assign strobe_on = (state_q == S_STROBE) || (state_q == S_WAITX);

    // D_OE only ever follows writes, so it can never overlap OE_N/IORD_N low.
    always_comb begin
        bus.req_ready  = (state_q == S_IDLE) && !bus.rst_req;
        bus.a          = bus_on ? addr_q : 16'h0000;
        bus.d_oe       = bus_on && write_q;
        bus.d_out      = (bus_on && write_q) ? wdata_q : 8'h00;
        bus.ce1_n      = !bus_on;
        bus.ce2_n      = 1'b1;
        bus.reg_n      = !(bus_on && (attr_q || io_q));
        bus.oe_n       = !(strobe_on && !io_q && !write_q);
        bus.we_n       = !(strobe_on && !io_q && write_q);
        bus.iord_n     = !(strobe_on && io_q && !write_q);
        bus.iowr_n     = !(strobe_on && io_q && write_q);
        bus.card_reset = (state_q == S_CRST);
        bus.rsp_valid  = (state_q == S_RESP);
        bus.rsp_rdata  = (state_q == S_RESP) ? rdata_q : 8'h00;
        bus.rsp_tmo    = (state_q == S_RESP) && tmo_q;
        bus.rsp_nopack = (state_q == S_RESP) && io_q && !write_q && !pack_q;
    end
endmodule
